// File: rtl/lock_pkg.sv
// Shared types and default constants for the combination-lock sequencer.
package lock_pkg;

    // Sequencer states; the encoding is also visible on the debug state port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        SETUP    = 3'd4,
        BURST    = 3'd5,
        LOCKOUT  = 3'd6
    } lock_state_t;

    // Digit and index widths for the default password geometry.
    localparam int DEF_DIGITS  = 4;
    localparam int DEF_DIGIT_W = 4;
    localparam int DEF_IDX_W   = $clog2(DEF_DIGITS);

    // Default timing constants (50 MHz system clock).
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 150_000_000;
    localparam int DEF_LOCKOUT_CYCLES = 250_000_000;
    localparam int DEF_CMP_TIMEOUT    = 15;

    // Width of the shared down-counter; covers the longest window.
    localparam int TIMER_W = 32;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window, the lockout window and
// the compare timeout. done is high in the last counted cycle, so a window
// loaded with N keeps its owner in place for exactly N cycles.
module lock_timer
    import lock_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         pause,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down to zero unless paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (!pause && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Sequencing controller for the combination lock: turns button pulses and
// switch digits into the per-digit write / compare / clear strobes for the
// code checker, and owns the attempt counter, unlock window, password-setup
// burst and post-failure lockout.
//
// Handshake: digit_req / submit_req / store_req are single-cycle pulses with
// no ready; a request is acted on in the cycle it is high or dropped. All
// outputs are registered, so every response appears one cycle later.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int DIGITS         = DEF_DIGITS,
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int CMP_TIMEOUT    = DEF_CMP_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             system_reset_n,
    input  logic                             digit_req,
    input  logic                             submit_req,
    input  logic                             store_req,
    input  logic [DIGIT_W-1:0]               digit,
    input  logic                             correct_password,
    input  logic                             incorrect_password,
    output logic [DIGIT_W-1:0]               bits,
    output logic [$clog2(DIGITS)-1:0]        digit_idx,
    output logic                             input_value,
    output logic                             store_value,
    output logic                             compare,
    output logic                             input_reset,
    output logic                             unlock,
    output logic                             sleep,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic [2:0]                       dbg_state
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = IDX_W + 1;
    localparam int FC_W  = $clog2(MAX_FAILS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGITS);

    lock_state_t              state, state_n;
    logic [CNT_W-1:0]         count_q, count_n;
    logic [DIGIT_W-1:0]       shadow_q [DIGITS];
    logic [DIGIT_W-1:0]       shadow_n [DIGITS];

    logic [DIGIT_W-1:0]       bits_n;
    logic [IDX_W-1:0]         idx_n;
    logic                     input_value_n, store_value_n, compare_n, input_reset_n;
    logic                     unlock_n, sleep_n;
    logic [FC_W-1:0]          fail_n;

    logic                     t_load, t_pause, t_done;
    logic [TIMER_W-1:0]       t_val;
    logic                     fail_evt, pass_evt;

    lock_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst_n    (system_reset_n),
        .load     (t_load),
        .load_val (t_val),
        .pause    (t_pause),
        .done     (t_done)
    );

    assign dbg_state = state;

    // State, digit counter, shadow buffer and every output are flops.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state       <= IDLE;
            count_q     <= '0;
            shadow_q    <= '{default: '0};
            bits        <= '0;
            digit_idx   <= '0;
            input_value <= 1'b0;
            store_value <= 1'b0;
            compare     <= 1'b0;
            input_reset <= 1'b0;
            unlock      <= 1'b0;
            sleep       <= 1'b0;
            fail_count  <= '0;
        end else begin
            state       <= state_n;
            count_q     <= count_n;
            shadow_q    <= shadow_n;
            bits        <= bits_n;
            digit_idx   <= idx_n;
            input_value <= input_value_n;
            store_value <= store_value_n;
            compare     <= compare_n;
            input_reset <= input_reset_n;
            unlock      <= unlock_n;
            sleep       <= sleep_n;
            fail_count  <= fail_n;
        end
    end

    // Next state, next outputs and timer control.
    always_comb begin
        state_n       = state;
        count_n       = count_q;
        shadow_n      = shadow_q;
        bits_n        = bits;
        idx_n         = digit_idx;
        input_value_n = 1'b0;
        store_value_n = 1'b0;
        compare_n     = 1'b0;
        input_reset_n = 1'b0;
        unlock_n      = unlock;
        sleep_n       = sleep;
        fail_n        = fail_count;
        t_load        = 1'b0;
        t_val         = '0;
        t_pause       = 1'b0;
        fail_evt      = 1'b0;
        pass_evt      = 1'b0;

        case (state)
            IDLE, ENTRY: begin
                // Submit outranks digit, but means nothing before any digit.
                if (submit_req && state == ENTRY) begin
                    if (count_q == FULL) begin
                        compare_n = 1'b1;
                        t_load    = 1'b1;
                        t_val     = TIMER_W'(CMP_TIMEOUT);
                        state_n   = CHECK;
                    end else begin
                        fail_evt = 1'b1;
                    end
                end else if (digit_req && count_q < FULL) begin
                    bits_n        = digit;
                    idx_n         = count_q[IDX_W-1:0];
                    input_value_n = 1'b1;
                    count_n       = count_q + CNT_W'(1);
                    state_n       = ENTRY;
                end
            end

            CHECK: begin
                // The checker needs the compare cycle itself; results and the
                // timeout only count from the following cycle.
                t_pause = compare;
                if (!compare) begin
                    if (incorrect_password) begin
                        fail_evt = 1'b1;
                    end else if (correct_password) begin
                        pass_evt = 1'b1;
                    end else if (t_done) begin
                        fail_evt = 1'b1;
                    end
                end
            end

            UNLOCKED: begin
                // Window expiry wins over a store request in its last cycle.
                if (t_done) begin
                    unlock_n = 1'b0;
                    state_n  = IDLE;
                end else if (store_req) begin
                    count_n = '0;
                    state_n = SETUP;
                end
            end

            SETUP: begin
                // The unlock window is frozen while a new password is typed.
                t_pause = 1'b1;
                if (submit_req) begin
                    if (count_q == FULL) begin
                        store_value_n = 1'b1;
                        idx_n         = '0;
                        bits_n        = shadow_q[0];
                        count_n       = CNT_W'(1);
                        state_n       = BURST;
                    end else begin
                        count_n = '0;
                        state_n = UNLOCKED;
                    end
                end else if (digit_req && count_q < FULL) begin
                    shadow_n[count_q[IDX_W-1:0]] = digit;
                    count_n = count_q + CNT_W'(1);
                end
            end

            BURST: begin
                // Slot 0 went out on entry; stream the rest, then relock.
                t_pause = 1'b1;
                if (count_q < FULL) begin
                    store_value_n = 1'b1;
                    idx_n         = count_q[IDX_W-1:0];
                    bits_n        = shadow_q[count_q[IDX_W-1:0]];
                    count_n       = count_q + CNT_W'(1);
                end else begin
                    unlock_n = 1'b0;
                    count_n  = '0;
                    state_n  = IDLE;
                end
            end

            LOCKOUT: begin
                if (t_done) begin
                    sleep_n = 1'b0;
                    fail_n  = '0;
                    count_n = '0;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        // Attempt outcomes shared by short submits, failed compares and timeouts.
        if (fail_evt) begin
            input_reset_n = 1'b1;
            count_n       = '0;
            if (int'(fail_count) + 1 >= MAX_FAILS) begin
                sleep_n = 1'b1;
                t_load  = 1'b1;
                t_val   = TIMER_W'(LOCKOUT_CYCLES);
                state_n = LOCKOUT;
            end else begin
                fail_n  = fail_count + FC_W'(1);
                state_n = IDLE;
            end
        end

        if (pass_evt) begin
            fail_n        = '0;
            input_reset_n = 1'b1;
            unlock_n      = 1'b1;
            count_n       = '0;
            t_load        = 1'b1;
            t_val         = TIMER_W'(UNLOCK_CYCLES);
            state_n       = UNLOCKED;
        end
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: table-driven cycle vectors plus
// hand-written sequences for the long windows and mid-operation resets.
`timescale 1ns/1ps
module tb_lock_sequencer;
    import lock_pkg::*;

    logic       clk = 1'b0;
    logic       system_reset_n = 1'b0;
    logic       digit_req = 1'b0, submit_req = 1'b0, store_req = 1'b0;
    logic [3:0] digit = '0;
    logic       correct_password = 1'b0, incorrect_password = 1'b0;
    logic [3:0] bits;
    logic [1:0] digit_idx;
    logic       input_value, store_value, compare, input_reset, unlock, sleep;
    logic [1:0] fail_count;
    logic [2:0] dbg_state;

    // Clock / reset
    always #5 clk = ~clk;

    lock_sequencer #(
        .DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3),
        .UNLOCK_CYCLES(10), .LOCKOUT_CYCLES(20), .CMP_TIMEOUT(4)
    ) dut (
        .clk(clk), .system_reset_n(system_reset_n),
        .digit_req(digit_req), .submit_req(submit_req), .store_req(store_req),
        .digit(digit), .correct_password(correct_password),
        .incorrect_password(incorrect_password),
        .bits(bits), .digit_idx(digit_idx), .input_value(input_value),
        .store_value(store_value), .compare(compare), .input_reset(input_reset),
        .unlock(unlock), .sleep(sleep), .fail_count(fail_count),
        .dbg_state(dbg_state)
    );

    // Vector table: stimulus records plus an expected-output queue.
    typedef struct {
        string name;
        int    req;   // {digit_req, submit_req, store_req}
        int    dig;
        int    res;   // {correct_password, incorrect_password}
    } vec_t;

    vec_t        vq[$];
    logic [16:0] exp_q[$];
    int          n_vec = 0;
    int          n_bad = 0;

    // Expected output word: bits, idx, iv, sv, cmp, ir, unlock, sleep, fc, state.
    function automatic logic [16:0] pk(input int b, input int i, input int iv, input int sv,
                                       input int cm, input int ir, input int ul, input int sl,
                                       input int fc, input lock_state_t st);
        return {4'(b), 2'(i), 1'(iv), 1'(sv), 1'(cm), 1'(ir), 1'(ul), 1'(sl), 2'(fc), st};
    endfunction

    function automatic logic [16:0] act();
        return {bits, digit_idx, input_value, store_value, compare, input_reset,
                unlock, sleep, fail_count, dbg_state};
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [16:0] e);
        logic [16:0] a;
        a = act();
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (bits,idx,iv,sv,cmp,ir,unl,slp,fc,st)",
                     name, a, e);
        end
    endtask

    // Driver: apply one cycle of inputs, check the registered response.
    task automatic apply(input string name, input int req, input int dig, input int res,
                         input logic [16:0] e);
        digit_req          = req[2];
        submit_req         = req[1];
        store_req          = req[0];
        digit              = 4'(dig);
        correct_password   = res[1];
        incorrect_password = res[0];
        @(posedge clk);
        #1;
        check(name, e);
        digit_req = 1'b0; submit_req = 1'b0; store_req = 1'b0;
        correct_password = 1'b0; incorrect_password = 1'b0; digit = '0;
    endtask

    task automatic add(input string name, input int req, input int dig, input int res,
                       input logic [16:0] e);
        vec_t v;
        v.name = name; v.req = req; v.dig = dig; v.res = res;
        vq.push_back(v);
        exp_q.push_back(e);
    endtask

    task automatic run_table();
        vec_t        v;
        logic [16:0] e;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            e = exp_q.pop_front();
            apply(v.name, v.req, v.dig, v.res, e);
        end
    endtask

    // Four digits from IDLE then a full submit; ends in the compare cycle.
    task automatic add_entry(input logic [15:0] ds, input int fc);
        int d;
        for (int i = 0; i < 4; i++) begin
            d = int'(ds[15-4*i -: 4]);
            add("digit", 4, d, 0, pk(d, i, 1, 0, 0, 0, 0, 0, fc, ENTRY));
        end
        add("submit", 2, 0, 0, pk(int'(ds[3:0]), 3, 0, 0, 1, 0, 0, 0, fc, CHECK));
    endtask

    task automatic do_reset();
        system_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        @(negedge clk);
        system_reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // 1: correct entry, result two cycles after compare, 10-cycle window.
        add_entry(16'h1234, 0);
        add("c0", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("c1", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("pass", 0, 0, 2, pk(4, 3, 0, 0, 0, 1, 1, 0, 0, UNLOCKED));
        run_table();
        for (int k = 1; k < 10; k++)
            apply("unlock_hold", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 1, 0, 0, UNLOCKED));
        apply("unlock_end", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // 2: three wrong attempts, then lockout with requests ignored.
        add_entry(16'h5678, 0);
        add("c0_result_ignored", 0, 0, 1, pk(8, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("fail1", 0, 0, 1, pk(8, 3, 0, 0, 0, 1, 0, 0, 1, IDLE));
        add_entry(16'h1111, 1);
        add("c0", 0, 0, 0, pk(1, 3, 0, 0, 0, 0, 0, 0, 1, CHECK));
        add("fail2", 0, 0, 1, pk(1, 3, 0, 0, 0, 1, 0, 0, 2, IDLE));
        add_entry(16'h2222, 2);
        add("c0", 0, 0, 0, pk(2, 3, 0, 0, 0, 0, 0, 0, 2, CHECK));
        add("fail3_lock", 0, 0, 1, pk(2, 3, 0, 0, 0, 1, 0, 1, 2, LOCKOUT));
        run_table();
        for (int k = 1; k < 20; k++)
            apply("lockout_hold", (k % 3 == 0) ? 1 : ((k % 3 == 1) ? 4 : 2), k, 2,
                  pk(2, 3, 0, 0, 0, 0, 0, 1, 2, LOCKOUT));
        apply("lockout_end", 0, 0, 0, pk(2, 3, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // 3: short submit is an immediate failure; a full submit times out.
        add("digit_after_lock", 4, 10, 0, pk(10, 0, 1, 0, 0, 0, 0, 0, 0, ENTRY));
        add("digit", 4, 11, 0, pk(11, 1, 1, 0, 0, 0, 0, 0, 0, ENTRY));
        add("short_submit", 2, 0, 0, pk(11, 1, 0, 0, 0, 1, 0, 0, 1, IDLE));
        add_entry(16'h3456, 1);
        for (int k = 0; k < 4; k++)
            add("wait_result", 0, 0, 0, pk(6, 3, 0, 0, 0, 0, 0, 0, 1, CHECK));
        add("timeout", 0, 0, 0, pk(6, 3, 0, 0, 0, 1, 0, 0, 2, IDLE));
        run_table();

        // 4: simultaneous correct and incorrect is a failure.
        do_reset();
        add_entry(16'h1234, 0);
        add("c0", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("both_results", 0, 0, 3, pk(4, 3, 0, 0, 0, 1, 0, 0, 1, IDLE));

        // 5a: short setup is discarded and the window resumes where it paused.
        add_entry(16'h4321, 1);
        add("c0", 0, 0, 0, pk(1, 3, 0, 0, 0, 0, 0, 0, 1, CHECK));
        add("pass", 0, 0, 2, pk(1, 3, 0, 0, 0, 1, 1, 0, 0, UNLOCKED));
        add("unlocked", 0, 0, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, UNLOCKED));
        add("store", 1, 0, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d9", 4, 9, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d8", 4, 8, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("short_setup", 2, 0, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, UNLOCKED));
        run_table();
        for (int k = 1; k < 8; k++)
            apply("resumed_hold", 0, 0, 0, pk(1, 3, 0, 0, 0, 0, 1, 0, 0, UNLOCKED));
        apply("resumed_end", 0, 0, 0, pk(1, 3, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // 5b: full setup bursts the shadow buffer out, then relocks.
        add_entry(16'h1357, 0);
        add("c0", 0, 0, 0, pk(7, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("pass", 0, 0, 2, pk(7, 3, 0, 0, 0, 1, 1, 0, 0, UNLOCKED));
        add("store", 1, 0, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d9", 4, 9, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d8", 4, 8, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d7", 4, 7, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_d6", 4, 6, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("setup_extra", 4, 5, 0, pk(7, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("burst0", 2, 0, 0, pk(9, 0, 0, 1, 0, 0, 1, 0, 0, BURST));
        add("burst1", 0, 0, 0, pk(8, 1, 0, 1, 0, 0, 1, 0, 0, BURST));
        add("burst2", 0, 0, 0, pk(7, 2, 0, 1, 0, 0, 1, 0, 0, BURST));
        add("burst3", 0, 0, 0, pk(6, 3, 0, 1, 0, 0, 1, 0, 0, BURST));
        add("burst_done", 0, 0, 0, pk(6, 3, 0, 0, 0, 0, 0, 0, 0, IDLE));
        run_table();

        // 6a: asynchronous reset in CHECK.
        add_entry(16'h2468, 0);
        run_table();
        #2 system_reset_n = 1'b0;
        #1 check("async_reset_check", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        @(negedge clk);
        system_reset_n = 1'b1;
        @(posedge clk);
        #1 check("release_check", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));

        // 6b: asynchronous reset in mid-BURST.
        add_entry(16'h1234, 0);
        add("c0", 0, 0, 0, pk(4, 3, 0, 0, 0, 0, 0, 0, 0, CHECK));
        add("pass", 0, 0, 2, pk(4, 3, 0, 0, 0, 1, 1, 0, 0, UNLOCKED));
        add("store", 1, 0, 0, pk(4, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        for (int k = 10; k < 14; k++)
            add("setup_digit", 4, k, 0, pk(4, 3, 0, 0, 0, 0, 1, 0, 0, SETUP));
        add("burst0", 2, 0, 0, pk(10, 0, 0, 1, 0, 0, 1, 0, 0, BURST));
        add("burst1", 0, 0, 0, pk(11, 1, 0, 1, 0, 0, 1, 0, 0, BURST));
        run_table();
        #2 system_reset_n = 1'b0;
        #1 check("async_reset_burst", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        @(negedge clk);
        system_reset_n = 1'b1;
        @(posedge clk);
        #1 check("release_burst", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE));
        apply("digit_after_reset", 4, 3, 0, pk(3, 0, 1, 0, 0, 0, 0, 0, 0, ENTRY));

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
